// File: rtl/collision_pkg.sv
// Shared types for the collision probe: screen geometry, FSM states, probe
// ordering and the helpers that map a probe index to a point and a side.
package collision_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned NUM_SIDES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    PRB_LEFT_TOP  = 3'd0,
    PRB_LEFT_BOT  = 3'd1,
    PRB_RIGHT_TOP = 3'd2,
    PRB_RIGHT_BOT = 3'd3,
    PRB_UP_LEFT   = 3'd4,
    PRB_UP_RIGHT  = 3'd5,
    PRB_DN_LEFT   = 3'd6,
    PRB_DN_RIGHT  = 3'd7
  } probe_e;

  typedef enum logic [1:0] {
    SIDE_LEFT   = 2'd0,
    SIDE_RIGHT  = 2'd1,
    SIDE_TOP    = 2'd2,
    SIDE_BOTTOM = 2'd3
  } side_e;

  typedef struct packed {
    logic [COORD_W-1:0] l;
    logic [COORD_W-1:0] r;
    logic [COORD_W-1:0] t;
    logic [COORD_W-1:0] b;
  } box_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  // Probes come in pairs per side, so the side is the index without its LSB.
  function automatic side_e probe_side(input probe_e p);
    logic [2:0] v;
    v = p;
    return side_e'(v[2:1]);
  endfunction

  // Pixel just outside the box for each probe; arithmetic wraps at 1024.
  function automatic point_t probe_point(input box_t bx, input probe_e p);
    point_t pt;
    pt = '0;
    case (p)
      PRB_LEFT_TOP:  begin pt.x = bx.l - COORD_W'(1); pt.y = bx.t;               end
      PRB_LEFT_BOT:  begin pt.x = bx.l - COORD_W'(1); pt.y = bx.b;               end
      PRB_RIGHT_TOP: begin pt.x = bx.r + COORD_W'(1); pt.y = bx.t;               end
      PRB_RIGHT_BOT: begin pt.x = bx.r + COORD_W'(1); pt.y = bx.b;               end
      PRB_UP_LEFT:   begin pt.x = bx.l;               pt.y = bx.t - COORD_W'(1); end
      PRB_UP_RIGHT:  begin pt.x = bx.r;               pt.y = bx.t - COORD_W'(1); end
      PRB_DN_LEFT:   begin pt.x = bx.l;               pt.y = bx.b + COORD_W'(1); end
      PRB_DN_RIGHT:  begin pt.x = bx.r;               pt.y = bx.b + COORD_W'(1); end
      default:       pt = '0;
    endcase
    return pt;
  endfunction

endpackage

// File: rtl/tile_addr_calc.sv
// Pixel point to tile ROM address; off-screen points are flagged and
// mapped to address 0. Row scaling is a constant shift-and-add.
module tile_addr_calc
  import collision_pkg::*;
#(
  parameter int unsigned MAP_COLS   = 40,
  parameter int unsigned MAP_ROWS   = 30,
  parameter int unsigned TILE_SHIFT = 4
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr_c,
  output logic               out_of_bounds_c
);

  localparam int unsigned PROD_W    = 16;
  localparam int unsigned COLS_BITW = 12;
  localparam logic [COLS_BITW-1:0] COLS_BITS = COLS_BITW'(MAP_COLS);

  logic [COORD_W-1:0] col;
  logic [COORD_W-1:0] row;
  logic [PROD_W-1:0]  row_scaled;

  always_comb begin
    col = x >> TILE_SHIFT;
    row = y >> TILE_SHIFT;
    row_scaled = '0;
    for (int k = 0; k < int'(COLS_BITW); k++) begin
      if (COLS_BITS[k]) row_scaled = row_scaled + (PROD_W'(row) << k);
    end
    // Map-size terms only matter for non-default maps smaller than the screen.
    out_of_bounds_c = (x > COORD_W'(SCREEN_W - 1)) || (y > COORD_W'(SCREEN_H - 1)) ||
                      (32'(col) >= MAP_COLS) || (32'(row) >= MAP_ROWS);
    addr_c = out_of_bounds_c ? '0 : ADDR_W'(row_scaled + PROD_W'(col));
  end

endmodule

// File: rtl/collision_probe.sv
// Per-frame tile collision probe: reads eight ROM tiles around the latched
// bounding box and reports which of the four directions are free.
module collision_probe
  import collision_pkg::*;
#(
  parameter int unsigned MAP_COLS   = 40,
  parameter int unsigned MAP_ROWS   = 30,
  parameter int unsigned TILE_SHIFT = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] BallL,
  input  logic [COORD_W-1:0] BallR,
  input  logic [COORD_W-1:0] BallT,
  input  logic [COORD_W-1:0] BallB,
  output logic [ADDR_W-1:0]  map_addr,
  input  logic               map_data,
  output logic               fLeft,
  output logic               fRight,
  output logic               fTop,
  output logic               fBottom,
  output logic               done
);

  state_e                 state_q, state_d;
  box_t                   box_q, box_d, box_in;
  probe_e                 idx_q, idx_d;
  logic                   all_issued_q, all_issued_d;
  // Address stage: probe whose address is on map_addr this cycle.
  logic                   pres_vld_q, pres_vld_d;
  probe_e                 pres_idx_q, pres_idx_d;
  logic                   pres_oob_q, pres_oob_d;
  // Data stage: probe whose ROM bit is on map_data this cycle.
  logic                   dat_vld_q, dat_vld_d;
  probe_e                 dat_idx_q, dat_idx_d;
  logic                   dat_oob_q, dat_oob_d;
  logic [NUM_SIDES-1:0]   blocked_q, blocked_d;
  logic [NUM_SIDES-1:0]   flags_q, flags_d;
  logic                   done_q, done_d;
  logic [ADDR_W-1:0]      map_addr_q, map_addr_d;

  point_t                 probe_pt;
  logic [ADDR_W-1:0]      calc_addr;
  logic                   calc_oob;
  side_e                  dat_side;

  assign box_in = '{l: BallL, r: BallR, t: BallT, b: BallB};

  // The first probe is computed from the live inputs so its address leaves on the latch edge.
  always_comb begin
    if (state_q == SCAN) probe_pt = probe_point(box_q, idx_q);
    else                 probe_pt = probe_point(box_in, PRB_LEFT_TOP);
  end

  tile_addr_calc #(
    .MAP_COLS   (MAP_COLS),
    .MAP_ROWS   (MAP_ROWS),
    .TILE_SHIFT (TILE_SHIFT)
  ) u_addr (
    .x               (probe_pt.x),
    .y               (probe_pt.y),
    .addr_c          (calc_addr),
    .out_of_bounds_c (calc_oob)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      box_q        <= '0;
      idx_q        <= PRB_LEFT_TOP;
      all_issued_q <= 1'b0;
      pres_vld_q   <= 1'b0;
      pres_idx_q   <= PRB_LEFT_TOP;
      pres_oob_q   <= 1'b0;
      dat_vld_q    <= 1'b0;
      dat_idx_q    <= PRB_LEFT_TOP;
      dat_oob_q    <= 1'b0;
      blocked_q    <= '0;
      flags_q      <= '0;
      done_q       <= 1'b0;
      map_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      box_q        <= box_d;
      idx_q        <= idx_d;
      all_issued_q <= all_issued_d;
      pres_vld_q   <= pres_vld_d;
      pres_idx_q   <= pres_idx_d;
      pres_oob_q   <= pres_oob_d;
      dat_vld_q    <= dat_vld_d;
      dat_idx_q    <= dat_idx_d;
      dat_oob_q    <= dat_oob_d;
      blocked_q    <= blocked_d;
      flags_q      <= flags_d;
      done_q       <= done_d;
      map_addr_q   <= map_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    box_d        = box_q;
    idx_d        = idx_q;
    all_issued_d = all_issued_q;
    pres_vld_d   = 1'b0;
    pres_idx_d   = PRB_LEFT_TOP;
    pres_oob_d   = 1'b0;
    dat_vld_d    = pres_vld_q;
    dat_idx_d    = pres_idx_q;
    dat_oob_d    = pres_oob_q;
    blocked_d    = blocked_q;
    flags_d      = flags_q;
    done_d       = 1'b0;
    map_addr_d   = '0;
    dat_side     = probe_side(dat_idx_q);

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d      = SCAN;
          box_d        = box_in;
          idx_d        = PRB_LEFT_BOT;
          all_issued_d = 1'b0;
          blocked_d    = '0;
          pres_vld_d   = 1'b1;
          pres_idx_d   = PRB_LEFT_TOP;
          pres_oob_d   = calc_oob;
          map_addr_d   = calc_addr;
        end
      end
      SCAN: begin
        if (!all_issued_q) begin
          pres_vld_d   = 1'b1;
          pres_idx_d   = idx_q;
          pres_oob_d   = calc_oob;
          map_addr_d   = calc_addr;
          idx_d        = probe_e'(3'(idx_q + 3'd1));
          all_issued_d = (idx_q == PRB_DN_RIGHT);
        end
        // Off-screen probes count as solid whatever the ROM returned.
        if (dat_vld_q) begin
          blocked_d[dat_side] = blocked_d[dat_side] | dat_oob_q | map_data;
          if (dat_idx_q == PRB_DN_RIGHT) state_d = COMMIT;
        end
      end
      COMMIT: begin
        flags_d = ~blocked_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign map_addr = map_addr_q;
  assign fLeft    = flags_q[SIDE_LEFT];
  assign fRight   = flags_q[SIDE_RIGHT];
  assign fTop     = flags_q[SIDE_TOP];
  assign fBottom  = flags_q[SIDE_BOTTOM];
  assign done     = done_q;

endmodule

// File: tb/tb_collision_probe.sv
// Self-checking bench for collision_probe: directed scenarios plus random
// boxes over random tile maps, checked against a geometric reference model.
module tb_collision_probe;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start;
  logic [9:0]  BallL, BallR, BallT, BallB;
  logic [10:0] map_addr;
  logic        map_data;
  logic        fLeft, fRight, fTop, fBottom, done;

  int          n_checks;
  int          n_fail;
  bit          rom [0:1199];
  logic [3:0]  model_prev;

  always #5 Clk = ~Clk;

  collision_probe dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .BallL       (BallL),
    .BallR       (BallR),
    .BallT       (BallT),
    .BallB       (BallB),
    .map_addr    (map_addr),
    .map_data    (map_data),
    .fLeft       (fLeft),
    .fRight      (fRight),
    .fTop        (fTop),
    .fBottom     (fBottom),
    .done        (done)
  );

  // Synchronous tile ROM: data valid the cycle after the address.
  always @(posedge Clk) map_data <= (map_addr < 11'd1200) ? rom[map_addr] : 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] cur_flags();
    return {fBottom, fTop, fRight, fLeft};
  endfunction

  // Reference: probe pixels from the box, wrap to 10 bits, off-screen is solid.
  task automatic model(input int l, r, t, b, output logic [3:0] free, output int addrs[8]);
    int px[8];
    int py[8];
    int x, y;
    bit solid;
    px = '{l - 1, l - 1, r + 1, r + 1, l, r, l, r};
    py = '{t, b, t, b, t - 1, t - 1, b + 1, b + 1};
    free = 4'hF;
    for (int i = 0; i < 8; i++) begin
      x = px[i] & 1023;
      y = py[i] & 1023;
      if (x > 639 || y > 479) begin
        solid    = 1'b1;
        addrs[i] = 0;
      end else begin
        addrs[i] = (y / 16) * 40 + (x / 16);
        solid    = rom[addrs[i]];
      end
      if (solid) free[i / 2] = 1'b0;
    end
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 1200; a++) rom[a] = 1'b0;
  endtask

  task automatic run_scan(input int l, r, t, b, input bit again, input bit scramble,
                          output int p6_addr);
    logic [3:0] exp_free;
    int ea[8];
    int sa[12];
    int done_cnt, done_at, max_a, off;
    bit ok;
    model(l, r, t, b, exp_free, ea);
    @(negedge Clk);
    BallL = 10'(l); BallR = 10'(r); BallT = 10'(t); BallB = 10'(b);
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    sa[0] = int'(map_addr);
    max_a = int'(map_addr);
    if (scramble) begin
      BallL = 10'($urandom); BallR = 10'($urandom);
      BallT = 10'($urandom); BallB = 10'($urandom);
    end
    done_cnt = 0;
    done_at  = -1;
    for (int k = 1; k <= 13; k++) begin
      if (again && k == 3) frame_start = 1'b1;
      @(posedge Clk); #1;
      frame_start = 1'b0;
      if (k < 12) sa[k] = int'(map_addr);
      if (int'(map_addr) > max_a) max_a = int'(map_addr);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == 9)  check("flags_hold", 32'(cur_flags()), 32'(model_prev));
      if (k == 10) check("flags", 32'(cur_flags()), 32'(exp_free));
    end
    check("done_count", done_cnt, 1);
    check("done_cycle", done_at, 10);
    off = -1;
    for (int o = 0; o <= 4; o++) begin
      ok = 1'b1;
      for (int i = 0; i < 8; i++) if (sa[o + i] != ea[i]) ok = 1'b0;
      if (ok && off < 0) off = o;
    end
    check("addr_seq", 32'(off >= 0), 1);
    check("addr_max", 32'(max_a <= 1199), 1);
    p6_addr = (off >= 0) ? sa[off + 6] : -1;
    model_prev = exp_free;
  endtask

  initial begin
    int p6;
    int l, r, t, b, dcnt;
    n_checks    = 0;
    n_fail      = 0;
    model_prev  = 4'h0;
    Reset_n     = 1'b0;
    frame_start = 1'b0;
    BallL = '0; BallR = '0; BallT = '0; BallB = '0;
    clear_rom();
    repeat (3) @(posedge Clk);
    #1;
    check("rst_flags", 32'(cur_flags()), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addr", 32'(map_addr), 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Open space
    run_scan(100, 126, 200, 226, 1'b0, 1'b0, p6);

    // Floor at tile row 15
    for (int c = 0; c < 40; c++) rom[15 * 40 + c] = 1'b1;
    run_scan(100, 126, 200, 239, 1'b0, 1'b0, p6);
    check("floor_probe6_addr", p6, 606);

    // Left screen edge via wrap
    clear_rom();
    run_scan(0, 26, 100, 126, 1'b0, 1'b0, p6);

    // Wall at tile column 10, then move away from it
    for (int rr = 0; rr < 30; rr++) rom[rr * 40 + 10] = 1'b1;
    run_scan(130, 159, 100, 126, 1'b0, 1'b1, p6);
    run_scan(130, 140, 100, 126, 1'b0, 1'b0, p6);

    // Second frame_start during a scan is dropped
    clear_rom();
    run_scan(100, 126, 200, 226, 1'b1, 1'b0, p6);

    // Reset in the middle of a scan
    @(negedge Clk);
    BallL = 10'd300; BallR = 10'd320; BallT = 10'd100; BallB = 10'd120;
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    check("midrst_flags", 32'(cur_flags()), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_addr", 32'(map_addr), 0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    model_prev = 4'h0;
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge Clk); #1;
      if (done) dcnt++;
    end
    check("midrst_no_done", dcnt, 0);

    // Random boxes over random maps, inputs scrambled after the latch edge
    for (int it = 0; it < 20; it++) begin
      for (int a = 0; a < 1200; a++) rom[a] = ($urandom_range(0, 99) < 12);
      l = (it % 5 == 0) ? 0 : int'($urandom_range(0, 700));
      r = (l + int'($urandom_range(0, 48))) & 1023;
      t = (it % 7 == 0) ? 0 : int'($urandom_range(0, 520));
      b = (t + int'($urandom_range(0, 48))) & 1023;
      if (it == 3) r = 1023;
      run_scan(l, r, t, b, 1'b0, 1'b1, p6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_probe.md
COLLISION_PROBE -- requirements
Module: collision_probe

Interface
REQ-001 SHALL declare parameter MAP_COLS, default 40, meaning tile-map width in tiles.
REQ-002 SHALL declare parameter MAP_ROWS, default 30, meaning tile-map height in tiles.
REQ-003 SHALL declare parameter TILE_SHIFT, default 4, meaning log2 of tile size in pixels (16 px).
REQ-004 SHALL have port Clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port Reset_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port frame_start, input, 1, meaning a one-cycle pulse, synchronous to Clk, that requests a scan.
REQ-007 SHALL have ports BallL, BallR, BallT, BallB, input, 10 each, meaning the character bounding box in pixels.
REQ-008 SHALL have port map_addr, output, 11, meaning the tile ROM address, row*MAP_COLS+col.
REQ-009 SHALL have port map_data, input, 1, meaning the ROM solid bit (1 = wall), valid one cycle after map_addr.
REQ-010 SHALL have ports fLeft, fRight, fTop, fBottom, output, 1 each, meaning 1 = free to move that way.
REQ-011 SHALL have port done, output, 1, meaning a one-cycle pulse when the flags are updated.

Function
REQ-012 SHALL use FSM states IDLE, SCAN and COMMIT only.
REQ-013 SHALL, in IDLE when frame_start=1, latch BallL/R/T/B, clear probe index to 0 and enter SCAN on that edge.
REQ-014 SHALL evaluate 8 probes in SCAN, in index order:
 - 0: (L-1, T); 1: (L-1, B)
 - 2: (R+1, T); 3: (R+1, B)
 - 4: (L, T-1); 5: (R, T-1)
 - 6: (L, B+1); 7: (R, B+1)
REQ-015 SHALL present probe i's address for exactly one cycle, then advance the index; the 10-bit probe arithmetic wraps modulo 1024.
REQ-016 SHALL compute col = x>>TILE_SHIFT and row = y>>TILE_SHIFT; map_addr = row*MAP_COLS+col, maximum 1199.
REQ-017 SHALL treat a probe with x>639 or y>479 (including wrap from 0-1=1023) as solid; its map_data is ignored and map_addr is forced to 0.
REQ-018 SHALL capture map_data for probe i on the edge after probe i's address is presented; solid results OR into a per-side blocked bit.
REQ-019 SHALL enter COMMIT after probe 7's data is captured; in COMMIT each flag = NOT blocked for its side, done=1 for one cycle, then IDLE.
REQ-020 SHALL update flags and done at the 10th rising edge after the edge that samples frame_start; the previous flag values hold unchanged until then.
REQ-021 SHALL ignore frame_start while in SCAN or COMMIT; the request is not queued.
REQ-022 SHALL ignore changes on BallL/R/T/B after the latch edge until the next scan.
REQ-023 SHALL drive map_addr=0 in IDLE and COMMIT.

Reset
REQ-024 SHALL, when Reset_n=0, force immediately: state IDLE, index 0, blocked bits 0, fLeft=fRight=fTop=fBottom=0, done=0, map_addr=0.
REQ-025 SHALL, on reset mid-scan, abandon the scan; after release no done occurs until a new frame_start.

Structure
REQ-026 SHALL place SCREEN_W=640, SCREEN_H=480, the FSM state enum and the probe-index enum in shared package collision_pkg.
REQ-027 SHALL implement REQ-016 and REQ-017 in one sub-module, tile_addr_calc (x,y -> addr, out_of_bounds), implemented with shifts and adds and no multiplier.

Verification
REQ-028 SHALL check open space: all-zero map, box L=100 R=126 T=200 B=226, pulse frame_start -> done 10 cycles later, all four flags=1.
REQ-029 SHALL check floor: tile row 15 solid (y 240..255), box T=200 B=239 -> fBottom=0, fLeft=fRight=fTop=1; map_addr for probe 6 = 15*40+6=606.
REQ-030 SHALL check screen edge: box L=0 R=26 T=100 B=126, empty map -> fLeft=0 via wrap rule, no ROM address >1199 issued, other flags=1.
REQ-031 SHALL check wall: tile col 10 solid, box R=159 -> fRight=0; moving box to R=140 on the next scan -> fRight=1.
REQ-032 SHALL check frame_start pulsed again 3 cycles into a scan -> exactly one done, at cycle 10 of the first scan.
REQ-033 SHALL check Reset_n low at cycle 5 of a scan -> flags=0 and done=0 immediately; no done after release until a new frame_start.
